// File: rtl/accu_trace_fifo.sv
// accu_trace_fifo: records (PC, accumulator) pairs whenever the accumulator changes and streams them out.
// Latency: an entry pushed at edge N is presented on the registered head right after edge N.
// Backpressure: trace_ready_i low holds the head stable; when full, new events are dropped and counted.
// Optional feature macro: ACCU_TRACE_TIMESTAMP_EN adds trace_ts_o and a 16-bit free-running cycle counter.
module accu_trace_fifo #(
  parameter int INS_ADDR_WIDTH = 6,
  parameter int MEM_WIDTH      = 8,
  parameter int DEPTH          = 16,
  parameter int DROP_CNT_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      nReset,
  input  logic [INS_ADDR_WIDTH-1:0] PC_Addr_i,
  input  logic [MEM_WIDTH-1:0]      Accu_i,
  input  logic                      trace_en_i,
  input  logic                      clear_i,
  output logic                      trace_valid_o,
  input  logic                      trace_ready_i,
  output logic [INS_ADDR_WIDTH-1:0] trace_addr_o,
  output logic [MEM_WIDTH-1:0]      trace_data_o,
  output logic [$clog2(DEPTH):0]    count_o,
  output logic                      overflow_o,
  output logic [DROP_CNT_WIDTH-1:0] drop_cnt_o
`ifdef ACCU_TRACE_TIMESTAMP_EN
  ,
  output logic [15:0]               trace_ts_o
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
`ifdef ACCU_TRACE_TIMESTAMP_EN
  localparam int TSW = 16;
  localparam int EW  = INS_ADDR_WIDTH + MEM_WIDTH + TSW;
`else
  localparam int EW  = INS_ADDR_WIDTH + MEM_WIDTH;
`endif

  logic [EW-1:0]             r_mem [DEPTH];
  logic [EW-1:0]             r_head;
  logic [PW-1:0]             r_wr_ptr;
  logic [PW-1:0]             r_rd_ptr;
  logic [CW-1:0]             r_count;
  logic [MEM_WIDTH-1:0]      r_last_accu;
  logic                      r_primed;
  logic                      r_overflow;
  logic [DROP_CNT_WIDTH-1:0] r_drop_cnt;
`ifdef ACCU_TRACE_TIMESTAMP_EN
  logic [TSW-1:0]            r_ts;
`endif

  logic          w_change;
  logic          w_valid;
  logic          w_pop;
  logic          w_full;
  logic          w_push;
  logic          w_drop;
  logic [PW-1:0] w_rd_next;
  logic [EW-1:0] w_entry;

  // The first enabled cycle after reset/clear always counts as a change so the trace has a starting point.
  assign w_change  = trace_en_i && (!r_primed || (Accu_i != r_last_accu));
  assign w_valid   = (r_count != '0);
  assign w_pop     = w_valid && trace_ready_i;
  assign w_full    = (r_count == CW'(DEPTH));
  // A simultaneous pop frees a slot, so a full FIFO can still accept.
  assign w_push    = w_change && (!w_full || w_pop);
  assign w_drop    = w_change && !w_push;
  assign w_rd_next = r_rd_ptr + PW'(1);
`ifdef ACCU_TRACE_TIMESTAMP_EN
  assign w_entry   = {PC_Addr_i, Accu_i, r_ts};
`else
  assign w_entry   = {PC_Addr_i, Accu_i};
`endif

  // Storage array: written at the tail on every accepted push; no reset needed since count gates reads.
  always_ff @(posedge clk) begin
    if (w_push && !clear_i) begin
      r_mem[r_wr_ptr] <= w_entry;
    end
  end

  // Registered head: load the next entry on pop, or bypass the incoming entry when it becomes the head.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      r_head <= '0;
    end else if (!clear_i) begin
      if (w_pop) begin
        if (r_count == CW'(1)) begin
          if (w_push) begin
            r_head <= w_entry;
          end
        end else begin
          r_head <= r_mem[w_rd_next];
        end
      end else if (w_push && !w_valid) begin
        r_head <= w_entry;
      end
    end
  end

  // Pointers and occupancy; clear dominates any push/pop in the same cycle.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (clear_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= w_rd_next;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Change-detection state; tracks the accumulator even when the push itself is dropped.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      r_last_accu <= '0;
      r_primed    <= 1'b0;
    end else if (clear_i) begin
      r_primed    <= 1'b0;
    end else if (w_change) begin
      r_last_accu <= Accu_i;
      r_primed    <= 1'b1;
    end
  end

  // Sticky overflow flag and saturating drop counter.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else if (clear_i) begin
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
      if (r_drop_cnt != '1) begin
        r_drop_cnt <= r_drop_cnt + DROP_CNT_WIDTH'(1);
      end
    end
  end

`ifdef ACCU_TRACE_TIMESTAMP_EN
  // Free-running cycle counter used to stamp entries; wraps naturally and is zeroed by clear.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      r_ts <= '0;
    end else if (clear_i) begin
      r_ts <= '0;
    end else begin
      r_ts <= r_ts + TSW'(1);
    end
  end

  assign trace_ts_o   = r_head[TSW-1:0];
`endif

  assign trace_valid_o = w_valid;
  assign trace_addr_o  = r_head[EW-1 -: INS_ADDR_WIDTH];
  assign trace_data_o  = r_head[EW-INS_ADDR_WIDTH-1 -: MEM_WIDTH];
  assign count_o       = r_count;
  assign overflow_o    = r_overflow;
  assign drop_cnt_o    = r_drop_cnt;

endmodule

// File: tb/tb_accu_trace_fifo.sv
module tb_accu_trace_fifo;
  localparam int AW    = 6;
  localparam int MW    = 8;
  localparam int DEPTH = 16;
  localparam int DW    = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          nReset;
  logic [AW-1:0] pc;
  logic [MW-1:0] acc;
  logic          en, clr, rdy;
  logic          trace_valid;
  logic [AW-1:0] trace_addr;
  logic [MW-1:0] trace_data;
  logic [CW-1:0] count;
  logic          overflow;
  logic [DW-1:0] drop_cnt;
`ifdef ACCU_TRACE_TIMESTAMP_EN
  logic [15:0]   trace_ts;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  accu_trace_fifo #(
    .INS_ADDR_WIDTH(AW), .MEM_WIDTH(MW), .DEPTH(DEPTH), .DROP_CNT_WIDTH(DW)
  ) dut (
    .clk(clk), .nReset(nReset), .PC_Addr_i(pc), .Accu_i(acc),
    .trace_en_i(en), .clear_i(clr),
    .trace_valid_o(trace_valid), .trace_ready_i(rdy),
    .trace_addr_o(trace_addr), .trace_data_o(trace_data),
    .count_o(count), .overflow_o(overflow), .drop_cnt_o(drop_cnt)
`ifdef ACCU_TRACE_TIMESTAMP_EN
    , .trace_ts_o(trace_ts)
`endif
  );

  // Behavioural reference model: a queue of entries plus the spec's scalar state.
  typedef struct {
    logic [AW-1:0] a;
    logic [MW-1:0] d;
    logic [15:0]   ts;
  } ent_t;

  ent_t        mq[$];
  bit          m_primed;
  logic [MW-1:0] m_last;
  bit          m_ovf;
  int          m_drop;
  logic [15:0] m_ts;

  task automatic model_reset();
    mq.delete();
    m_primed = 0;
    m_last   = '0;
    m_ovf    = 0;
    m_drop   = 0;
    m_ts     = '0;
  endtask

  // Advance one clock: apply the model's rules to the inputs seen at the edge, then return at the falling edge.
  task automatic tick();
    bit   ch, pp;
    int   sz;
    ent_t e;
    @(posedge clk);
    ch = en && (!m_primed || acc != m_last);
    sz = mq.size();
    pp = (sz > 0) && rdy;
    if (clr) begin
      mq.delete();
      m_ovf    = 0;
      m_drop   = 0;
      m_primed = 0;
      m_ts     = '0;
    end else begin
      if (ch) begin
        m_last   = acc;
        m_primed = 1;
      end
      if (pp) void'(mq.pop_front());
      if (ch && (sz < DEPTH || pp)) begin
        e.a = pc; e.d = acc; e.ts = m_ts;
        mq.push_back(e);
      end else if (ch) begin
        m_ovf = 1;
        if (m_drop < (1 << DW) - 1) m_drop++;
      end
      m_ts = m_ts + 16'd1;
    end
    @(negedge clk);
  endtask

  task automatic do_clear();
    clr = 1; en = 0; rdy = 0;
    tick();
    clr = 0;
  endtask

  task automatic test_reset();
    nReset = 0; pc = '0; acc = '0; en = 0; clr = 0; rdy = 0;
    model_reset();
    #3;
    n_tests++; if (trace_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %0h exp 0", trace_valid); end
    n_tests++; if (count !== '0) begin n_fail++; $display("FAIL reset_count got %0d exp 0", count); end
    n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow got %0h exp 0", overflow); end
    n_tests++; if (drop_cnt !== '0) begin n_fail++; $display("FAIL reset_drop got %0d exp 0", drop_cnt); end
    n_tests++; if ({trace_addr, trace_data} !== '0) begin n_fail++; $display("FAIL reset_head got %0h exp 0", {trace_addr, trace_data}); end
    @(negedge clk);
    nReset = 1;
  endtask

  task automatic test_first_event();
    en = 1; acc = 8'h00; pc = '0; rdy = 0;
    for (int i = 0; i < 5; i++) tick();
    n_tests++; if (count !== CW'(1)) begin n_fail++; $display("FAIL first_count got %0d exp 1", count); end
    n_tests++; if (trace_valid !== 1'b1) begin n_fail++; $display("FAIL first_valid got %0h exp 1", trace_valid); end
    n_tests++; if ({trace_addr, trace_data} !== 14'h0) begin n_fail++; $display("FAIL first_head got %0h exp 0", {trace_addr, trace_data}); end
  endtask

  task automatic test_sequence();
    logic [MW-1:0] seq[6];
    logic [13:0]   exp_q[$];
    logic [13:0]   obs_q[$];
    seq[0] = 8'h55; seq[1] = 8'h55; seq[2] = 8'h50;
    seq[3] = 8'hF0; seq[4] = 8'hFF; seq[5] = 8'h00;
    exp_q = '{{6'd1, 8'h55}, {6'd3, 8'h50}, {6'd4, 8'hF0}, {6'd5, 8'hFF}, {6'd6, 8'h00}};
    do_clear();
    rdy = 1; en = 1;
    for (int i = 0; i < 6; i++) begin
      pc = AW'(i + 1); acc = seq[i];
      tick();
      if (i == 0) begin
        n_tests++; if (trace_valid !== 1'b1) begin n_fail++; $display("FAIL seq_latency got %0h exp 1", trace_valid); end
      end
      if (trace_valid === 1'b1) obs_q.push_back({trace_addr, trace_data});
    end
    en = 0;
    for (int i = 0; i < 2; i++) begin
      tick();
      if (trace_valid === 1'b1) obs_q.push_back({trace_addr, trace_data});
    end
    n_tests++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL seq_len got %0d exp %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_tests++; if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL seq_entry%0d got %0h exp %0h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_overflow();
    do_clear();
    en = 1; rdy = 0;
    for (int i = 0; i < 20; i++) begin
      pc = AW'(i); acc = MW'(i * 7 + 1);
      tick();
    end
    n_tests++; if (count !== CW'(16)) begin n_fail++; $display("FAIL ovf_count got %0d exp 16", count); end
    n_tests++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag got %0h exp 1", overflow); end
    n_tests++; if (drop_cnt !== DW'(4)) begin n_fail++; $display("FAIL ovf_drop got %0d exp 4", drop_cnt); end
    en = 0; rdy = 1;
    for (int i = 0; i < 16; i++) begin
      n_tests++;
      if (trace_valid !== 1'b1 || {trace_addr, trace_data} !== {AW'(i), MW'(i * 7 + 1)}) begin
        n_fail++; $display("FAIL ovf_drain%0d got v=%0h %0h exp v=1 %0h", i, trace_valid, {trace_addr, trace_data}, {AW'(i), MW'(i * 7 + 1)});
      end
      tick();
    end
    n_tests++; if (trace_valid !== 1'b0 || count !== '0) begin n_fail++; $display("FAIL ovf_empty got v=%0h c=%0d exp v=0 c=0", trace_valid, count); end
  endtask

  task automatic test_full_pop();
    en = 1; rdy = 0;
    for (int i = 0; i < 16; i++) begin
      pc = AW'(i); acc = MW'(8'h80 + i);
      tick();
    end
    n_tests++; if (count !== CW'(16)) begin n_fail++; $display("FAIL fullpop_fill got %0d exp 16", count); end
    pc = AW'(33); acc = 8'hC0; rdy = 1;
    tick();
    en = 0; rdy = 0;
    n_tests++; if (count !== CW'(16)) begin n_fail++; $display("FAIL fullpop_count got %0d exp 16", count); end
    n_tests++; if (drop_cnt !== DW'(4)) begin n_fail++; $display("FAIL fullpop_drop got %0d exp 4", drop_cnt); end
    n_tests++; if (trace_data !== 8'h81) begin n_fail++; $display("FAIL fullpop_head got %0h exp 81", trace_data); end
    rdy = 1;
    for (int i = 0; i < 15; i++) tick();
    rdy = 0;
    n_tests++; if ({trace_addr, trace_data} !== {6'd33, 8'hC0}) begin n_fail++; $display("FAIL fullpop_tail got %0h exp %0h", {trace_addr, trace_data}, {6'd33, 8'hC0}); end
  endtask

  task automatic test_saturation();
    do_clear();
    en = 1; rdy = 0;
    for (int i = 0; i < 16; i++) begin acc = MW'(8'h80 + i); tick(); end
    for (int i = 0; i < 300; i++) begin acc = (i % 2 == 0) ? 8'h11 : 8'h22; tick(); end
    n_tests++; if (drop_cnt !== DW'(255)) begin n_fail++; $display("FAIL sat_drop got %0d exp 255", drop_cnt); end
    n_tests++; if (count !== CW'(16)) begin n_fail++; $display("FAIL sat_count got %0d exp 16", count); end
  endtask

  task automatic test_clear();
    do_clear();
    en = 1; rdy = 0;
    for (int i = 0; i < 17; i++) begin pc = AW'(i); acc = MW'(8'h40 + i); tick(); end
    en = 0; rdy = 1;
    for (int i = 0; i < 11; i++) tick();
    rdy = 0;
    n_tests++; if (count !== CW'(5) || overflow !== 1'b1) begin n_fail++; $display("FAIL clr_setup got c=%0d o=%0h exp c=5 o=1", count, overflow); end
    clr = 1; en = 1; acc = 8'h77;
    tick();
    clr = 0;
    n_tests++; if (count !== '0 || trace_valid !== 1'b0) begin n_fail++; $display("FAIL clr_empty got c=%0d v=%0h exp c=0 v=0", count, trace_valid); end
    n_tests++; if (overflow !== 1'b0 || drop_cnt !== '0) begin n_fail++; $display("FAIL clr_flags got o=%0h d=%0d exp 0 0", overflow, drop_cnt); end
    tick();
    n_tests++; if (count !== CW'(1) || trace_data !== 8'h77) begin n_fail++; $display("FAIL clr_reprime got c=%0d d=%0h exp c=1 d=77", count, trace_data); end
    en = 0;
  endtask

  task automatic test_async_reset();
`ifdef ACCU_TRACE_TIMESTAMP_EN
    logic [15:0] ts0;
`endif
    do_clear();
    en = 1; rdy = 0;
    for (int i = 0; i < 7; i++) begin pc = AW'(i); acc = MW'(8'h10 + i); tick(); end
    n_tests++; if (count !== CW'(7)) begin n_fail++; $display("FAIL arst_setup got %0d exp 7", count); end
    #1 nReset = 0;
    #2;
    n_tests++; if (count !== '0 || trace_valid !== 1'b0) begin n_fail++; $display("FAIL arst_async got c=%0d v=%0h exp 0 0", count, trace_valid); end
    n_tests++; if (overflow !== 1'b0 || drop_cnt !== '0) begin n_fail++; $display("FAIL arst_flags got o=%0h d=%0d exp 0 0", overflow, drop_cnt); end
    #1 nReset = 1;
    model_reset();
    tick();
    n_tests++; if (count !== CW'(1) || trace_data !== 8'h16) begin n_fail++; $display("FAIL arst_resume got c=%0d d=%0h exp c=1 d=16", count, trace_data); end
`ifdef ACCU_TRACE_TIMESTAMP_EN
    en = 0; tick(); tick();
    en = 1; acc = 8'h17; tick();
    en = 0;
    ts0 = trace_ts;
    rdy = 1; tick(); rdy = 0;
    n_tests++; if (trace_ts - ts0 !== 16'd3) begin n_fail++; $display("FAIL ts_delta got %0d exp 3", trace_ts - ts0); end
`endif
    en = 0;
  endtask

  task automatic test_random();
    logic [MW-1:0] vals[4];
    int thresh;
    vals[0] = 8'h00; vals[1] = 8'h3C; vals[2] = 8'hA5; vals[3] = 8'hFF;
    thresh = 5;
    for (int c = 0; c < 3000; c++) begin
      if (c % 200 == 0) thresh = $urandom_range(0, 10);
      pc  = AW'($urandom_range(0, 63));
      acc = vals[$urandom_range(0, 3)];
      en  = ($urandom_range(0, 3) != 0);
      rdy = ($urandom_range(0, 9) < thresh);
      clr = ($urandom_range(0, 99) == 0);
      n_tests++; if (count !== CW'(mq.size())) begin n_fail++; $display("FAIL rnd_count c%0d got %0d exp %0d", c, count, mq.size()); end
      n_tests++; if (trace_valid !== (mq.size() > 0)) begin n_fail++; $display("FAIL rnd_valid c%0d got %0h exp %0h", c, trace_valid, mq.size() > 0); end
      n_tests++; if (overflow !== m_ovf) begin n_fail++; $display("FAIL rnd_ovf c%0d got %0h exp %0h", c, overflow, m_ovf); end
      n_tests++; if (drop_cnt !== DW'(m_drop)) begin n_fail++; $display("FAIL rnd_drop c%0d got %0d exp %0d", c, drop_cnt, m_drop); end
      if (mq.size() > 0) begin
        n_tests++;
        if ({trace_addr, trace_data} !== {mq[0].a, mq[0].d}) begin
          n_fail++; $display("FAIL rnd_head c%0d got %0h exp %0h", c, {trace_addr, trace_data}, {mq[0].a, mq[0].d});
        end
`ifdef ACCU_TRACE_TIMESTAMP_EN
        n_tests++; if (trace_ts !== mq[0].ts) begin n_fail++; $display("FAIL rnd_ts c%0d got %0h exp %0h", c, trace_ts, mq[0].ts); end
`endif
      end
      tick();
    end
    clr = 0; en = 0; rdy = 0;
  endtask

  initial begin
    test_reset();
    test_first_event();
    test_sequence();
    test_overflow();
    test_full_pop();
    test_saturation();
    test_clear();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
